// File: rtl/fifo_burst_packer.sv
// Packs show-ahead FIFO words into valid/ready bursts of up to BURST_LEN beats.
// Define BURST_TIMEOUT_EN to close partial packets after TIMEOUT idle cycles.
module fifo_burst_packer #(
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [WIDTH-1:0] m_data,
  output logic             m_valid,
  output logic             m_last,
  input  logic             m_ready
);

  localparam int CW = $clog2(BURST_LEN) + 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] END_CNT = CW'(BURST_LEN - 1);

  logic [WIDTH-1:0] r_stg_data;
  logic             r_stg_vld;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_m_data;
  logic             r_m_valid;
  logic             r_m_last;

  logic w_out_free;
  logic w_at_end;
  logic w_tmo;
  logic w_move;
  logic w_pop;
  logic w_last_nxt;

  assign w_out_free = !r_m_valid || m_ready;
  assign w_at_end   = (r_cnt == END_CNT);

`ifdef BURST_TIMEOUT_EN
  logic [TW-1:0] r_tmr;
  logic          w_tmr_run;

  // Timer only runs while a non-final word sits waiting for a successor
  assign w_tmr_run = r_stg_vld && fifo_empty && !w_at_end && w_out_free;
  assign w_tmo     = w_tmr_run && (r_tmr == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr <= '0;
    end else if (w_move || !fifo_empty) begin
      r_tmr <= '0;
    end else if (w_tmr_run) begin
      r_tmr <= r_tmr + TW'(1);
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  assign w_move = w_out_free && r_stg_vld &&
                  (w_at_end || !fifo_empty || w_tmo);
  assign w_last_nxt = w_at_end || (fifo_empty && w_tmo);
  assign w_pop = !fifo_empty && (!r_stg_vld || w_move);

  assign fifo_rd_en = w_pop && rst_n;
  assign m_data     = r_m_data;
  assign m_valid    = r_m_valid;
  assign m_last     = r_m_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_data   <= '0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_cnt      <= '0;
      r_stg_data <= '0;
      r_stg_vld  <= 1'b0;
    end else begin
      if (w_move) begin
        r_m_valid <= 1'b1;
        r_m_data  <= r_stg_data;
        r_m_last  <= w_last_nxt;
        r_cnt     <= w_last_nxt ? '0 : r_cnt + CW'(1);
      end else if (r_m_valid && m_ready) begin
        r_m_valid <= 1'b0;
      end
      if (w_pop) begin
        r_stg_data <= fifo_dout;
        r_stg_vld  <= 1'b1;
      end else if (w_move) begin
        r_stg_vld <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fifo_burst_packer.md
# fifo_burst_packer

Downstream consumer of the show-ahead FIFO: pops words from the FIFO read side (`dout`/`empty`/`rd_en`) and emits them as valid/ready packets of at most `BURST_LEN` beats with a `last` marker. A one-word look-ahead stage register decides whether a word is the final beat of its packet before the word is presented. The block sustains one beat per cycle while the FIFO stays non-empty.

## Interface
- `WIDTH`, 8, data width; must match the FIFO.
- `BURST_LEN`, 4, maximum beats per packet; ≥1.
- `TIMEOUT`, 8, idle cycles before a partial packet is closed; ≥1; used only with `BURST_TIMEOUT_EN`.

- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `fifo_dout`  in  WIDTH  FIFO head word, valid whenever `fifo_empty`=0.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  pop request; head is consumed at the edge where it is 1.
- `m_data`  out  WIDTH  packet beat data.
- `m_valid`  out  1  beat valid.
- `m_last`  out  1  final beat of the packet.
- `m_ready`  in  1  downstream accept.

## Operation
- State:
  - Stage register `stg_data`/`stg_vld`.
  - Output register `m_data`/`m_valid`/`m_last`.
  - Beat counter `cnt`, 0..BURST_LEN-1, `$clog2(BURST_LEN)+1` bits.
  - Idle timer `tmr`, 0..TIMEOUT-1.
- Reset:
  - `m_valid`=0, `m_last`=0, `m_data`=0.
  - `stg_vld`=0, `cnt`=0, `tmr`=0.
  - `fifo_rd_en` is forced 0 while `rst_n`=0.
- `out_free` = !m_valid || m_ready.
- `at_end` = (cnt == BURST_LEN-1).
- `tmo` = timer expired (see Configuration).
- Move (stage → output) when `out_free && stg_vld && (at_end || !fifo_empty || tmo)`. On a move:
  - `m_valid`←1, `m_data`←`stg_data`.
  - `m_last`←`at_end || (fifo_empty && tmo)`.
  - `cnt`←`m_last_next ? 0 : cnt+1`.
- Pop (`fifo_rd_en`=1) when `!fifo_empty && (!stg_vld || move)`. On a pop: `stg_data`←`fifo_dout`, `stg_vld`←1. A move without a pop clears `stg_vld`.
- Output drain: if `m_valid && m_ready` and there is no move, `m_valid`←0. `m_data` and `m_last` hold their values.
- Output stability: while `m_valid && !m_ready`, `m_data`/`m_last` must not change.
- Packets never span an empty FIFO unless a successor word arrives before the timeout expires.
- `BURST_LEN`=1: every beat has `m_last`=1, and no look-ahead wait is needed.

## Timing
- Head word present at edge 0, stage and output empty:
  - Stage loads at edge 1.
  - `m_valid` rises at edge 2, if a successor is present or `at_end` holds.
- Steady state with a non-empty FIFO and `m_ready`=1: one pop and one beat per cycle. `fifo_rd_en` stays high continuously.
- Back-pressure (`m_ready`=0 with `m_valid`=1): move is blocked. The stage is held, and `fifo_rd_en`=0 once the stage is full.
- Simultaneous drain and move in one cycle: `m_valid` stays 1 and the new beat replaces the old one.
- `fifo_empty` rising while the stage is full and `!at_end`: the stage waits. The timer runs only in that condition: `stg_vld && fifo_empty && !at_end && out_free`.
- `tmr` resets to 0 on any move or when `fifo_empty`=0.
- Asynchronous reset mid-packet: the in-flight output and stage words are dropped, `cnt`→0, and the next packet starts fresh.

## Configuration
- `BURST_TIMEOUT_EN` defined:
  - `tmo` = (`tmr` == TIMEOUT-1) while the timer condition holds.
  - A partial packet closes after TIMEOUT idle cycles with `m_last`=1.
- `BURST_TIMEOUT_EN` undefined:
  - The timer is not built and `tmo`=0.
  - The held stage word waits indefinitely for a successor or for `at_end`.
  - Partial packets are only emitted once more data arrives.

## Test plan
- **Streaming:** BURST_LEN=4, FIFO preloaded with 0x01..0x08, `m_ready`=1 → beats 0x01..0x08 on consecutive cycles, `m_last` on 0x04 and 0x08, first `m_valid` 2 cycles after release.
- **Back-pressure:** same stream, `m_ready` low for 3 cycles during beat 0x02 → 0x02 is held stable, no beat is lost or duplicated, and `fifo_rd_en`=0 while the stage is full.
- **Timeout:** with `BURST_TIMEOUT_EN`, TIMEOUT=8, push only 0x11, 0x12 → 0x11 (`last`=0) is emitted. 0x12 is emitted with `last`=1 exactly 8 cycles after the FIFO goes empty, and `cnt` returns to 0.
- **No timeout:** without `BURST_TIMEOUT_EN`, same stimulus → 0x12 is never emitted. A later push of 0x13 releases 0x12 with `last`=0.
- **Single-beat packets:** BURST_LEN=1, push 0xAA, 0xBB → both beats have `m_last`=1, and 0xAA is presented without waiting for 0xBB.
- **Reset mid-packet:** assert `rst_n`=0 for 1 cycle after 2 beats of a 4-beat packet → `m_valid`=0 immediately, and after release the next packet has `m_last` on its 4th beat.
